// File: rtl/clock_ratio_detector.sv
// Measures the rising-to-rising period of Din in Clk cycles, classifies it as /2, /4, /8 or /16 and tracks lock and stall timeout.
// Latency 2 cycles from the sampled Din edge, no backpressure; CRD_DUTY_CHECK_EN adds a 50% high-time check to classification.
module clock_ratio_detector #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Din,
    input  logic             En,
    output logic [CNT_W-1:0] Period,
    output logic [2:0]       Ratio,
    output logic             Valid,
    output logic             Locked,
    output logic             Timeout
);

    localparam int               MW        = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_CNT);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1;
    logic             r_s2;
    logic             r_sp;
    logic             w_rise;
    logic [CNT_W-1:0] r_cnt;
    logic [MW-1:0]    r_match;
    logic [MW-1:0]    w_match_nxt;
    logic [CNT_W-1:0] r_period;
    logic [2:0]       r_ratio;
    logic [2:0]       w_code;
    logic             r_valid;
    logic             r_locked;
    logic             r_timeout;
    logic             w_arm_edge;
    logic             w_meas_edge;
    logic             w_sat;
`ifdef CRD_DUTY_CHECK_EN
    logic [CNT_W-1:0] r_hi;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_sp <= 1'b0;
        end else begin
            r_s1 <= Din;
            r_s2 <= r_s1;
            r_sp <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_sp;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!En) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_ARM;
                S_ARM:     if (w_rise) w_state_nxt = S_MEASURE;
                S_MEASURE: if (w_sat)  w_state_nxt = S_ARM;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A rise always wins over saturation, so a full-scale period is still reported.
    always_comb begin
        w_arm_edge  = En && (r_state == S_ARM) && w_rise;
        w_meas_edge = En && (r_state == S_MEASURE) && w_rise;
        w_sat       = En && (r_state == S_MEASURE) && !w_rise && (r_cnt == CNT_MAX);
    end

    always_comb begin
        w_code = 3'd0;
        case (r_cnt)
            CNT_W'(2):  w_code = 3'd1;
            CNT_W'(4):  w_code = 3'd2;
            CNT_W'(8):  w_code = 3'd3;
            CNT_W'(16): w_code = 3'd4;
            default:    w_code = 3'd0;
        endcase
`ifdef CRD_DUTY_CHECK_EN
        if (r_hi != (r_cnt >> 1)) w_code = 3'd0;
`endif
    end

    // The previously reported Ratio doubles as the code history for lock matching.
    always_comb begin
        w_match_nxt = '0;
        if (w_code == 3'd0)          w_match_nxt = '0;
        else if (w_code != r_ratio)  w_match_nxt = MW'(1);
        else if (r_match == MATCH_MAX) w_match_nxt = r_match;
        else                         w_match_nxt = r_match + MW'(1);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt     <= '0;
            r_match   <= '0;
            r_period  <= '0;
            r_ratio   <= 3'd0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
`ifdef CRD_DUTY_CHECK_EN
            r_hi      <= '0;
`endif
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            if (!En) begin
                r_cnt    <= '0;
                r_match  <= '0;
                r_ratio  <= 3'd0;
                r_locked <= 1'b0;
            end else if (w_arm_edge) begin
                r_cnt <= CNT_W'(1);
`ifdef CRD_DUTY_CHECK_EN
                r_hi  <= CNT_W'(1);
`endif
            end else if (w_meas_edge) begin
                r_period <= r_cnt;
                r_valid  <= 1'b1;
                r_ratio  <= w_code;
                r_match  <= w_match_nxt;
                r_locked <= (w_match_nxt == MATCH_MAX);
                r_cnt    <= CNT_W'(1);
`ifdef CRD_DUTY_CHECK_EN
                r_hi     <= CNT_W'(1);
`endif
            end else if (w_sat) begin
                r_timeout <= 1'b1;
                r_locked  <= 1'b0;
                r_ratio   <= 3'd0;
                r_match   <= '0;
                r_cnt     <= '0;
            end else if (r_state == S_MEASURE) begin
                r_cnt <= r_cnt + CNT_W'(1);
`ifdef CRD_DUTY_CHECK_EN
                r_hi  <= r_hi + CNT_W'(r_s2);
`endif
            end
        end
    end

    assign Period  = r_period;
    assign Ratio   = r_ratio;
    assign Valid   = r_valid;
    assign Locked  = r_locked;
    assign Timeout = r_timeout;

endmodule

// File: doc/clock_ratio_detector.md
# clock_ratio_detector

Measures the period of an incoming divided clock in `Clk` cycles and classifies it as a divide-by-2, 4, 8 or 16 ratio. It is the receiving end of our clock-divider outputs. It is used to check, on-chip or in the bench, that a divided clock, whether from the local divider or from an external source, has the expected ratio and is stable. It reports each measured period, a ratio code, a lock flag, and a timeout on a stalled input.

## Interface
- `CNT_W`, 8: width of the period counter and of `Period`; the saturation value is 2^CNT_W-1.
- `LOCK_CNT`, 4: number of consecutive identical nonzero classifications needed to assert `Locked`; must be ≥2.

Ports:
- `Clk` input 1: the only clock; all state updates on the rising edge.
- `Rst` input 1: asynchronous, active-low reset.
- `Din` input 1: divided clock under test; asynchronous to `Clk`.
- `En` input 1: measurement enable; low forces IDLE.
- `Period` output CNT_W: last measured rising-to-rising distance, in `Clk` cycles.
- `Ratio` output 3: 0 = unknown, 1 = /2, 2 = /4, 3 = /8, 4 = /16.
- `Valid` output 1: one-cycle pulse when `Period` and `Ratio` update.
- `Locked` output 1: stable ratio detected.
- `Timeout` output 1: one-cycle pulse when the counter saturates with no `Din` edge.

## Operation
- Reset (`Rst`=0, asynchronous): all outputs 0, state IDLE, counters 0, synchronizer flops 0.
- `Din` passes through a 2-flop synchronizer (`s1`, `s2`) and then one history flop `sp`.
- The internal signal `rise` = `s2 & ~sp`.
- **IDLE**:
  - Entered when `En`=0, from any state, on the next edge.
  - Counter = 0, `Locked` = 0, `Ratio` = 0, match count = 0.
  - `Period` holds its value.
  - Goes to ARM when `En`=1.
- **ARM**:
  - Waits for `rise`.
  - On `rise`: counter = 1, go to MEASURE.
  - No `Valid` is produced for this first edge.
- **MEASURE**:
  - Each cycle, counter = counter + 1.
  - On `rise`:
    - `Period` = counter and `Valid` = 1.
    - Counter restarts at 1.
    - `Ratio` = classification of the counter value: 2→1, 4→2, 8→3, 16→4, any other value→0.
- Lock, evaluated on each `Valid`:
  - Nonzero code equal to the previous code: match count increments, saturating at `LOCK_CNT`.
  - Nonzero code different from the previous code: match count = 1.
  - Code 0: match count = 0.
  - `Locked` = (match count == `LOCK_CNT`). It deasserts on the same edge as the first mismatching `Valid`.
- Timeout:
  - Condition: in MEASURE, counter == 2^CNT_W-1 and no `rise`.
  - Actions: `Timeout` = 1 for one cycle, `Locked` = 0, `Ratio` = 0, match count = 0, go to ARM.
  - `Period` holds its value.
- Simultaneous events:
  - `En`=0 overrides `rise` and timeout.
  - `rise` overrides timeout: a period equal to the saturation value is reported with `Ratio` = 0.
- The counter never wraps.
- Reset asserted mid-measurement: immediate clear; measurement restarts from ARM after `Rst` releases with `En`=1.

## Timing
- A `Din` rising edge meeting setup before `Clk` edge N sets `s1` at N and `s2` at N+1, so `rise` is high between edges N+1 and N+2.
- `Valid`, `Period`, `Ratio` and `Locked` update at edge N+2: latency is 2 cycles from the sampled edge.
- `Period` equals the exact cycle distance between consecutive sampled rising edges.
- Period 2 (`Din` toggling every `Clk`, same-domain source) yields `Valid` every 2 cycles.
- `Timeout` fires 2^CNT_W-1 cycles after the last `rise`-driven edge; with `CNT_W`=8 that is 255 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `CRD_DUTY_CHECK_EN` defined:
  - A second counter measures high time (cycles with `s2`=1) in each period.
  - A period is classified nonzero only if high time == `Period`>>1; otherwise `Ratio` = 0, and the lock rules for code 0 apply.
  - The high counter resets with the period counter.
- Macro undefined: duty cycle is ignored; classification is by period only; no high-time counter is present.

## Test plan
- Reset: run locked on /4, pull `Rst`=0 between `Clk` edges → all outputs 0 immediately, before the next edge. Release `Rst` → state ARM; no `Valid` until the second `Din` rise.
- /2 input (`Din` toggles every `Clk`), `En`=1 → `Valid` every 2 cycles, `Period`=2, `Ratio`=1. `Locked`=1 on the 4th `Valid` with `LOCK_CNT`=4.
- /16 input (8 high, 8 low) → `Period`=16, `Ratio`=4, `Locked` after 4 `Valid`s.
- Ratio switch /4 → /8 while locked → `Locked` drops on the first `Period`=8 `Valid`. `Ratio`=3, and `Locked` reasserts on the 4th consecutive /8 `Valid`.
- Period 6, then `Din` held low → `Valid` with `Ratio`=0 and `Locked`=0. `Timeout` pulses 255 cycles after the last rise (`CNT_W`=8), then the block returns to ARM.
- 3-high/1-low, period 4 → `Ratio`=0 with `CRD_DUTY_CHECK_EN` defined; `Ratio`=2 without it.
